// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
//   ctrl_state_e : sequencer state (run / waiting on data memory)
//   Fwd*         : ALU operand-select encodings (register file, EX_MEM, MEM_WB)
//   RegAddrW     : default register index width
package pipeline_ctrl_pkg;

  localparam int unsigned RegAddrW = 5;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StMwait = 1'b1
  } ctrl_state_e;

  localparam logic [1:0] FwdReg = 2'b00;
  localparam logic [1:0] FwdMem = 2'b10;
  localparam logic [1:0] FwdWb  = 2'b01;

endpackage

// File: rtl/hazard_detect_unit.sv
// Purely combinational register-dependency compares for the 5-stage pipeline.
// Config macro: HAZARD_FORWARD_EN
//   defined   : fwd_a/fwd_b select EX_MEM/MEM_WB results for the ID_EX sources
//               (ex_rs1/ex_rs2, wb_rd/wb_reg_wr ports present); only load-use stalls.
//   undefined : no forwarding (fwd = register file); raw_stall flags any used ID source
//               that matches a pending write in EX or MEM.
// Ports:
//   id_rs1/id_rs2, id_rs1_used/id_rs2_used : sources of the instruction in ID
//   ex_rd/ex_reg_wr/ex_mem_rd              : ID_EX destination, reg write, load
//   mem_rd/mem_reg_wr                      : EX_MEM destination, reg write
//   wb_rd/wb_reg_wr, ex_rs1/ex_rs2         : forwarding build only
//   load_use, raw_stall                    : stall requests
//   fwd_a, fwd_b                           : ALU operand selects
module hazard_detect_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = RegAddrW
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_wr,
  input  logic                  ex_mem_rd,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_wr,
`ifdef HAZARD_FORWARD_EN
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_wr,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
`endif
  output logic                  load_use,
  output logic                  raw_stall,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

  // x0 is hard-wired to zero, so a write to it never creates a dependency.
  function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] rs, input logic rs_used,
                                   input logic [REG_ADDR_W-1:0] rd, input logic rd_wr);
    return rs_used && rd_wr && (rd != '0) && (rd == rs);
  endfunction

  logic ex_hit;

  assign ex_hit = reg_hit(id_rs1, id_rs1_used, ex_rd, ex_reg_wr) |
                  reg_hit(id_rs2, id_rs2_used, ex_rd, ex_reg_wr);

  assign load_use = ex_mem_rd & ex_hit;

`ifdef HAZARD_FORWARD_EN
  // EX_MEM holds the younger result, so it wins over MEM_WB.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (reg_hit(rs, 1'b1, mem_rd, mem_reg_wr)) return FwdMem;
    if (reg_hit(rs, 1'b1, wb_rd, wb_reg_wr))   return FwdWb;
    return FwdReg;
  endfunction

  assign raw_stall = 1'b0;
  assign fwd_a     = fwd_sel(ex_rs1);
  assign fwd_b     = fwd_sel(ex_rs2);
`else
  logic mem_hit;

  // WB is excluded: the register file writes in the first half-cycle before ID reads.
  assign mem_hit   = reg_hit(id_rs1, id_rs1_used, mem_rd, mem_reg_wr) |
                     reg_hit(id_rs2, id_rs2_used, mem_rd, mem_reg_wr);
  assign raw_stall = ex_hit | mem_hit;
  assign fwd_a     = FwdReg;
  assign fwd_b     = FwdReg;
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/freeze sequencer for the 5-stage RV32I pipeline.
// Config macro: HAZARD_FORWARD_EN (adds ex_rs1/ex_rs2 and ALU forwarding; see
// hazard_detect_unit). Default build stalls on every EX/MEM register dependency.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   id_*, ex_*, mem_*, wb_*       : pipeline register fields used for hazard checks
//   ex_branch_taken, dmem_ready   : control-flow redirect, data memory handshake
//   *_en, *_flush                 : pipeline register enables and bubble inserts
//   fwd_a, fwd_b                  : ALU operand selects
//   dmem_err                      : sticky data-memory timeout flag
//   stall_cnt, flush_cnt          : saturating performance counters
// Priority: memory freeze > branch flush > data stall.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = RegAddrW,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_wr,
  input  logic                  ex_mem_rd,
`ifdef HAZARD_FORWARD_EN
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
`endif
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_wr,
  input  logic                  mem_mem_rd,
  input  logic                  mem_mem_wr,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_wr,
  input  logic                  ex_branch_taken,
  input  logic                  dmem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  dmem_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int unsigned TmoW = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_e     state_q, state_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            dmem_err_q, dmem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use, raw_stall, data_stall;
  logic freeze, branch_flush, stall_inc;
  logic [1:0] hdu_fwd_a, hdu_fwd_b;

  hazard_detect_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hdu (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd       (ex_rd),
    .ex_reg_wr   (ex_reg_wr),
    .ex_mem_rd   (ex_mem_rd),
    .mem_rd      (mem_rd),
    .mem_reg_wr  (mem_reg_wr),
`ifdef HAZARD_FORWARD_EN
    .wb_rd       (wb_rd),
    .wb_reg_wr   (wb_reg_wr),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
`endif
    .load_use    (load_use),
    .raw_stall   (raw_stall),
    .fwd_a       (hdu_fwd_a),
    .fwd_b       (hdu_fwd_b)
  );

`ifndef HAZARD_FORWARD_EN
  // Without forwarding the WB stage never causes a hazard.
  logic unused_wb;
  assign unused_wb = ^{wb_rd, wb_reg_wr};
`endif

  // In the default build raw_stall already covers load-use; with forwarding it is tied low.
  assign data_stall = load_use | raw_stall;

  // MWAIT keeps the freeze even if the access flags glitch while the pipe is held.
  assign freeze       = (mem_mem_rd | mem_mem_wr | (state_q == StMwait)) & ~dmem_ready;
  assign branch_flush = ex_branch_taken & ~freeze;
  assign stall_inc    = freeze | (~ex_branch_taken & data_stall);

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    fwd_a       = FwdReg;
    fwd_b       = FwdReg;
    // Outputs sit at their reset values for the whole time rst is asserted.
    if (!rst) begin
      fwd_a = hdu_fwd_a;
      fwd_b = hdu_fwd_b;
      if (freeze) begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (data_stall) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:   if ((mem_mem_rd | mem_mem_wr) && !dmem_ready) state_d = StMwait;
      StMwait: if (dmem_ready) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    tmo_d      = '0;
    dmem_err_d = dmem_err_q;
    if (state_q == StMwait && !dmem_ready) begin
      tmo_d = (tmo_q < TmoW'(MEM_TIMEOUT)) ? tmo_q + 1'b1 : tmo_q;
      if (tmo_d == TmoW'(MEM_TIMEOUT)) dmem_err_d = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && stall_cnt_q != '1)    stall_cnt_d = stall_cnt_q + 1'b1;
    if (branch_flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      tmo_q       <= '0;
      dmem_err_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      dmem_err_q  <= dmem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign dmem_err  = dmem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int unsigned RW  = 5;
  localparam int unsigned CW  = 4;
  localparam int unsigned TMO = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_rs1_used, id_rs2_used, ex_reg_wr, ex_mem_rd;
  logic          mem_reg_wr, mem_mem_rd, mem_mem_wr, wb_reg_wr;
  logic          ex_branch_taken, dmem_ready;
`ifdef HAZARD_FORWARD_EN
  logic [RW-1:0] ex_rs1, ex_rs2;
`endif
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush, dmem_err;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W  (RW),
    .CNT_W       (CW),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .ex_rd           (ex_rd),
    .ex_reg_wr       (ex_reg_wr),
    .ex_mem_rd       (ex_mem_rd),
`ifdef HAZARD_FORWARD_EN
    .ex_rs1          (ex_rs1),
    .ex_rs2          (ex_rs2),
`endif
    .mem_rd          (mem_rd),
    .mem_reg_wr      (mem_reg_wr),
    .mem_mem_rd      (mem_mem_rd),
    .mem_mem_wr      (mem_mem_wr),
    .wb_rd           (wb_rd),
    .wb_reg_wr       (wb_reg_wr),
    .ex_branch_taken (ex_branch_taken),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .dmem_err        (dmem_err),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  // en = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id_flush, id_ex_flush}
  typedef struct {
    string         name;
    logic [RW-1:0] id_rs1, id_rs2;
    logic          u1, u2;
    logic [RW-1:0] ex_rd;
    logic          ex_reg_wr, ex_mem_rd;
    logic [RW-1:0] mem_rd;
    logic          mem_reg_wr, mem_mem_rd, mem_mem_wr;
    logic [RW-1:0] wb_rd;
    logic          wb_reg_wr, br, rdy;
    logic [RW-1:0] ex_rs1, ex_rs2;
    logic [4:0]    en;
    logic [1:0]    fl, fa, fb;
  } vec_t;

  typedef struct {
    string         name;
    logic [4:0]    en;
    logic [1:0]    fl, fa, fb;
    logic [CW-1:0] sc, fc;
    logic          chk_err, err;
  } exp_t;

  exp_t          sb[$];
  vec_t          vecs[$];
  int unsigned   n_tests = 0;
  int unsigned   n_fail  = 0;
  logic [CW-1:0] m_stall = '0;
  logic [CW-1:0] m_flush = '0;

  function automatic vec_t nop(input string name);
    vec_t v;
    v.name = name;
    v.id_rs1 = '0; v.id_rs2 = '0; v.u1 = 1'b0; v.u2 = 1'b0;
    v.ex_rd = '0; v.ex_reg_wr = 1'b0; v.ex_mem_rd = 1'b0;
    v.mem_rd = '0; v.mem_reg_wr = 1'b0; v.mem_mem_rd = 1'b0; v.mem_mem_wr = 1'b0;
    v.wb_rd = '0; v.wb_reg_wr = 1'b0; v.br = 1'b0; v.rdy = 1'b1;
    v.ex_rs1 = '0; v.ex_rs2 = '0;
    v.en = 5'b11111; v.fl = 2'b00; v.fa = 2'b00; v.fb = 2'b00;
    return v;
  endfunction

  // Load in EX writing x5, ID reads x5 through rs1.
  function automatic vec_t lu(input string name);
    vec_t v = nop(name);
    v.id_rs1 = 5'd5; v.u1 = 1'b1;
    v.ex_rd = 5'd5; v.ex_reg_wr = 1'b1; v.ex_mem_rd = 1'b1;
    v.en = 5'b00111; v.fl = 2'b01;
    return v;
  endfunction

  function automatic vec_t mw(input string name, input logic rdy);
    vec_t v = nop(name);
    v.mem_mem_rd = 1'b1; v.rdy = rdy;
    if (!rdy) v.en = 5'b00000;
    return v;
  endfunction

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; id_rs1_used = v.u1; id_rs2_used = v.u2;
    ex_rd = v.ex_rd; ex_reg_wr = v.ex_reg_wr; ex_mem_rd = v.ex_mem_rd;
    mem_rd = v.mem_rd; mem_reg_wr = v.mem_reg_wr;
    mem_mem_rd = v.mem_mem_rd; mem_mem_wr = v.mem_mem_wr;
    wb_rd = v.wb_rd; wb_reg_wr = v.wb_reg_wr;
    ex_branch_taken = v.br; dmem_ready = v.rdy;
`ifdef HAZARD_FORWARD_EN
    ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2;
`endif
  endtask

  task automatic check_one();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    cmp({e.name, ".en"}, 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(e.en));
    cmp({e.name, ".flush"}, 32'({if_id_flush, id_ex_flush}), 32'(e.fl));
    cmp({e.name, ".fwd"}, 32'({fwd_a, fwd_b}), 32'({e.fa, e.fb}));
    cmp({e.name, ".stall_cnt"}, 32'(stall_cnt), 32'(e.sc));
    cmp({e.name, ".flush_cnt"}, 32'(flush_cnt), 32'(e.fc));
    if (e.chk_err) cmp({e.name, ".dmem_err"}, 32'(dmem_err), 32'(e.err));
    // Counter model: a stall or freeze holds the PC; a branch flushes IF_ID.
    if (!e.en[4] && m_stall != '1) m_stall = m_stall + 1'b1;
    if (e.fl[1] && m_flush != '1)  m_flush = m_flush + 1'b1;
  endtask

  task automatic apply(input vec_t v, input logic chk_err, input logic exp_err);
    exp_t e;
    @(posedge clk);
    #1;
    drive(v);
    e.name = v.name; e.en = v.en; e.fl = v.fl; e.fa = v.fa; e.fb = v.fb;
    e.sc = m_stall; e.fc = m_flush; e.chk_err = chk_err; e.err = exp_err;
    sb.push_back(e);
    @(negedge clk);
    check_one();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    drive(nop("init"));
    rst = 1'b1;
    #3;
    cmp("reset.en", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'h1f);
    cmp("reset.flush", 32'({if_id_flush, id_ex_flush}), 32'h0);
    cmp("reset.stall_cnt", 32'(stall_cnt), 32'h0);
    cmp("reset.flush_cnt", 32'(flush_cnt), 32'h0);
    cmp("reset.dmem_err", 32'(dmem_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back(nop("idle"));
    vecs.push_back(lu("load_use"));
    vecs.push_back(nop("after_load_use"));
    v = lu("branch_over_lu"); v.br = 1'b1; v.en = 5'b11111; v.fl = 2'b11;
    vecs.push_back(v);
    v = lu("load_x0"); v.id_rs1 = '0; v.ex_rd = '0; v.en = 5'b11111; v.fl = 2'b00;
    vecs.push_back(v);
    v = lu("rs1_unused"); v.u1 = 1'b0; v.en = 5'b11111; v.fl = 2'b00;
    vecs.push_back(v);
    v = lu("load_rs2"); v.id_rs1 = '0; v.u1 = 1'b0; v.id_rs2 = 5'd9; v.u2 = 1'b1;
    v.ex_rd = 5'd9;
    vecs.push_back(v);
    v = lu("load_no_regwr"); v.ex_reg_wr = 1'b0; v.en = 5'b11111; v.fl = 2'b00;
    vecs.push_back(v);
`ifdef HAZARD_FORWARD_EN
    v = nop("fwd_mem_over_wb"); v.mem_rd = 5'd7; v.mem_reg_wr = 1'b1;
    v.wb_rd = 5'd7; v.wb_reg_wr = 1'b1; v.ex_rs1 = 5'd7; v.fa = 2'b10;
    vecs.push_back(v);
    v = nop("fwd_wb_only"); v.wb_rd = 5'd7; v.wb_reg_wr = 1'b1; v.ex_rs1 = 5'd7; v.fa = 2'b01;
    vecs.push_back(v);
    v = nop("fwd_b_mem"); v.mem_rd = 5'd4; v.mem_reg_wr = 1'b1; v.ex_rs2 = 5'd4; v.fb = 2'b10;
    vecs.push_back(v);
    v = nop("fwd_x0"); v.mem_reg_wr = 1'b1; v.wb_reg_wr = 1'b1;
    vecs.push_back(v);
    v = nop("alu_dep_no_stall"); v.id_rs1 = 5'd3; v.u1 = 1'b1; v.ex_rd = 5'd3;
    v.ex_reg_wr = 1'b1;
    vecs.push_back(v);
`else
    v = nop("raw_ex"); v.id_rs1 = 5'd3; v.u1 = 1'b1; v.ex_rd = 5'd3; v.ex_reg_wr = 1'b1;
    v.en = 5'b00111; v.fl = 2'b01;
    vecs.push_back(v);
    v = nop("raw_mem"); v.id_rs2 = 5'd7; v.u2 = 1'b1; v.mem_rd = 5'd7; v.mem_reg_wr = 1'b1;
    v.en = 5'b00111; v.fl = 2'b01;
    vecs.push_back(v);
    v = nop("raw_wb_ignored"); v.id_rs1 = 5'd7; v.u1 = 1'b1; v.wb_rd = 5'd7; v.wb_reg_wr = 1'b1;
    vecs.push_back(v);
    v = nop("raw_mem_x0"); v.u2 = 1'b1; v.mem_reg_wr = 1'b1;
    vecs.push_back(v);
`endif
    // Three-cycle data memory wait, then release.
    vecs.push_back(mw("mwait_1", 1'b0));
    vecs.push_back(mw("mwait_2", 1'b0));
    vecs.push_back(mw("mwait_3", 1'b0));
    vecs.push_back(mw("mwait_release", 1'b1));
    // Freeze beats a branch; the release cycle lets the branch through.
    v = mw("freeze_branch", 1'b0); v.mem_mem_rd = 1'b0; v.mem_mem_wr = 1'b1; v.br = 1'b1;
    vecs.push_back(v);
    v = mw("release_branch", 1'b1); v.mem_mem_rd = 1'b0; v.mem_mem_wr = 1'b1; v.br = 1'b1;
    v.fl = 2'b11;
    vecs.push_back(v);
    vecs.push_back(nop("idle_end"));

    foreach (vecs[i]) apply(vecs[i], 1'b1, 1'b0);

    // Timeout: ready held low for MEM_TIMEOUT+2 cycles.
    for (int i = 0; i < int'(TMO) + 2; i++) apply(mw("tmo_wait", 1'b0), 1'b0, 1'b0);
    apply(mw("tmo_release", 1'b1), 1'b1, 1'b1);
    apply(nop("tmo_hold_1"), 1'b1, 1'b1);
    apply(nop("tmo_hold_2"), 1'b1, 1'b1);

    // Asynchronous reset in the middle of a wait.
    apply(mw("pre_rst_wait_1", 1'b0), 1'b1, 1'b1);
    apply(mw("pre_rst_wait_2", 1'b0), 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    cmp("rst_mwait.en", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'h1f);
    cmp("rst_mwait.flush", 32'({if_id_flush, id_ex_flush}), 32'h0);
    cmp("rst_mwait.stall_cnt", 32'(stall_cnt), 32'h0);
    cmp("rst_mwait.flush_cnt", 32'(flush_cnt), 32'h0);
    cmp("rst_mwait.dmem_err", 32'(dmem_err), 32'h0);
    m_stall = '0;
    m_flush = '0;
    @(negedge clk);
    drive(nop("post_rst"));
    rst = 1'b0;
    apply(nop("post_rst"), 1'b1, 1'b0);
    apply(lu("post_rst_load_use"), 1'b1, 1'b0);
    apply(nop("post_rst_idle"), 1'b1, 1'b0);

    cmp("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
